genius_playback: RTL and testbench

Playback sequencer for the Genius game datapath. On a start pulse from the main game controller, it walks the sequence memory from address 0 to `length-1` and lights the matching colour LED for each item, with speed-dependent on/gap timing. It then reports completion with a one-cycle `done` pulse. It owns the memory read port and the four LED outputs while `busy` is high; the main controller owns them otherwise.

---
 rtl/genius_playback_pkg.sv | 36 +++
 rtl/genius_playback_phase_timer.sv | 39 +++
 rtl/genius_playback.sv | 160 ++++++++++++++++
 tb/tb_genius_playback.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_playback_pkg.sv
// Shared types for the Genius playback sequencer.
//   color_t          : colour code carried in sequence memory
//   playback_state_t : playback FSM states
//   color_to_leds    : colour code -> one-hot LED vector {yellow, blue, green, red}
package genius_playback_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHOW,
    GAP,
    DONE
  } playback_state_t;

  function automatic logic [3:0] color_to_leds(color_t c);
    logic [3:0] leds;
    leds = 4'b0000;
    case (c)
      RED:     leds = 4'b0001;
      GREEN:   leds = 4'b0010;
      BLUE:    leds = 4'b0100;
      YELLOW:  leds = 4'b1000;
      default: leds = 4'b0000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/genius_playback_phase_timer.sv
// Loadable down-counter used to time the LED on and gap phases.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load value_i into the counter on this edge
//   value_i    : phase length in clocks (>= 1)
//   expired_o  : high in the last cycle of the loaded phase
module genius_playback_phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // A phase of N cycles starts with N in the counter, so the last cycle
  // of the phase is the one where the counter reads 1.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/genius_playback.sv
// Genius playback sequencer: on start, reads sequence memory from address 0
// to length-1 and lights the matching colour LED for each item, with
// speed-dependent on time followed by an all-off gap, then pulses done.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : start request (IDLE only) / level abort to IDLE
//   length, speed     : item count and fast(1)/slow(0), sampled with start
//   sequence_item     : memory read data, valid the cycle after mem_rd
//   mem_rd, addr      : memory read strobe and address
//   led_*             : one-hot colour LEDs
//   busy, done        : playback in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// FETCH | mem_rd with addr = idx
// LOAD  | capture colour, load on-time
// SHOW  | LED lit for the on-time
// GAP   | all LEDs off for the gap time
// DONE  | one-cycle done pulse
module genius_playback
  import genius_playback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 2,
  parameter int unsigned FAST_ON_CYCLES = 12_500_000,
  parameter int unsigned SLOW_ON_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  speed,
  input  logic [DATA_WIDTH-1:0] sequence_item,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  led_red,
  output logic                  led_green,
  output logic                  led_blue,
  output logic                  led_yellow,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned ON_MAX  = (SLOW_ON_CYCLES > FAST_ON_CYCLES) ? SLOW_ON_CYCLES
                                                                      : FAST_ON_CYCLES;
  localparam int unsigned CYC_MAX = (ON_MAX > GAP_CYCLES) ? ON_MAX : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(CYC_MAX + 1);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  playback_state_t       state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  spd_q, spd_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;

  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_value;
  logic                  tmr_expired;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic                  last_item;
  logic [3:0]            leds;

  genius_playback_phase_timer #(
    .WIDTH(TMR_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    spd_d     = spd_q;
    idx_d     = idx_q;
    color_d   = color_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    // len_q is never 0 outside IDLE/DONE, so len_q-1 is a valid item index.
    last_item   = ({1'b0, idx_q} == (len_q - LEN_ONE));

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len_clamped;
          spd_d   = speed;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        color_d   = sequence_item;
        tmr_load  = 1'b1;
        tmr_value = spd_q ? TMR_W'(FAST_ON_CYCLES) : TMR_W'(SLOW_ON_CYCLES);
        state_d   = SHOW;
      end
      SHOW: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
          tmr_value = TMR_W'(GAP_CYCLES);
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tmr_expired) begin
          if (last_item) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      spd_q   <= 1'b0;
      idx_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      spd_q   <= spd_d;
      idx_q   <= idx_d;
      color_q <= color_d;
    end
  end

  // Outputs decode registered state only.
  assign leds       = (state_q == SHOW) ? color_to_leds(color_t'(color_q)) : 4'b0000;
  assign led_red    = leds[0];
  assign led_green  = leds[1];
  assign led_blue   = leds[2];
  assign led_yellow = leds[3];
  assign mem_rd     = (state_q == FETCH);
  assign addr       = idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_genius_playback.sv
// Bench for genius_playback with short phase lengths. A behavioural model
// derives every cycle's outputs from (start cycle, length, speed, memory)
// and is compared each cycle; directed tests add literal expectations.
module tb_genius_playback;

  localparam int AW   = 5;
  localparam int DW   = 2;
  localparam int ON_F = 4;
  localparam int ON_S = 8;
  localparam int GAPC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          speed = 1'b0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] sequence_item = '0;
  logic          mem_rd;
  logic [AW-1:0] addr;
  logic          led_red, led_green, led_blue, led_yellow;
  logic          busy, done;

  genius_playback #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .FAST_ON_CYCLES(ON_F),
    .SLOW_ON_CYCLES(ON_S),
    .GAP_CYCLES    (GAPC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .length       (length),
    .speed        (speed),
    .sequence_item(sequence_item),
    .mem_rd       (mem_rd),
    .addr         (addr),
    .led_red      (led_red),
    .led_green    (led_green),
    .led_blue     (led_blue),
    .led_yellow   (led_yellow),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Sync-read memory; read data is garbage except the cycle after mem_rd.
  logic [1:0] mem [32];
  always @(posedge clk) sequence_item <= mem_rd ? mem[addr] : 2'($urandom);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  // ---------------- behavioural model ----------------
  int cyc   = 0;
  bit m_act = 1'b0;
  int m_e   = 0;
  int m_len = 0;
  bit m_spd = 1'b0;

  function automatic int on_of(bit s);
    return s ? ON_F : ON_S;
  endfunction

  function automatic int total_of(int l, bit s);
    return (l == 0) ? 1 : l * (2 + on_of(s) + GAPC) + 1;
  endfunction

  // d = cycles since the start edge (d=1 is the first busy cycle)
  always @(posedge clk) begin
    int  d;
    bit  prev_busy;
    cyc++;
    d = cyc - m_e;
    prev_busy = m_act && d >= 1 && d <= total_of(m_len, m_spd);
    if (!rst_n) m_act = 1'b0;
    else if (prev_busy && abort) m_act = 1'b0;
    else if (!prev_busy && start) begin
      m_act = 1'b1;
      m_e   = cyc;
      m_len = (int'(length) > 32) ? 32 : int'(length);
      m_spd = speed;
    end else if (m_act && d >= total_of(m_len, m_spd)) m_act = 1'b0;
  end

  // {mem_rd, addr[4:0], yellow, blue, green, red, busy, done}
  function automatic logic [11:0] expect_at(int d);
    logic [11:0] v;
    int on, p_len, tot, k, p;
    v     = '0;
    on    = on_of(m_spd);
    p_len = 2 + on + GAPC;
    tot   = total_of(m_len, m_spd);
    if (d >= 1 && d <= tot) begin
      v[1] = 1'b1;
      v[0] = (d == tot);
      if (m_len > 0 && d <= m_len * p_len) begin
        k = (d - 1) / p_len;
        p = (d - 1) % p_len;
        if (p == 0) begin
          v[11]   = 1'b1;
          v[10:6] = k[4:0];
        end
        if (p >= 2 && p < 2 + on) v[5:2] = 4'b0001 << mem[k];
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    logic [11:0] want, got;
    if (!rst_n) want = '0;
    else if (m_act) want = expect_at(cyc - m_e + 1);
    else want = '0;
    got = {mem_rd, addr, led_yellow, led_blue, led_green, led_red, busy, done};
    if (rst_n && !want[11]) got[10:6] = '0;
    check($sformatf("cycle %0d outputs", cyc), 32'(got), 32'(want));
  end

  // ---------------- event monitor for directed checks ----------------
  int         t_e = 0;
  int         done_cnt = 0;
  int         done_d = -1;
  int         led_d = -1;
  logic [3:0] led_v = '0;
  int         rd_d[$];
  int         rd_a[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        rd_d.push_back(cyc - t_e + 1);
        rd_a.push_back(int'(addr));
      end
      if (done) begin
        done_cnt++;
        done_d = cyc - t_e + 1;
      end
      if (led_d < 0 && {led_yellow, led_blue, led_green, led_red} != 4'b0000) begin
        led_d = cyc - t_e + 1;
        led_v = {led_yellow, led_blue, led_green, led_red};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_d.delete();
    rd_a.delete();
    done_cnt = 0;
    done_d   = -1;
    led_d    = -1;
    led_v    = '0;
  endtask

  task automatic do_start(input int len, input bit spd);
    clear_mon();
    length = 6'(len);
    speed  = spd;
    start  = 1'b1;
    tick();
    t_e   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int b;
    b = budget;
    while (done_cnt == 0 && b > 0) begin
      tick();
      b--;
    end
    check({name, " done seen"}, (done_cnt != 0) ? 32'd1 : 32'd0, 32'd1);
    tick();
    tick();
  endtask

  task automatic wait_d(input int target);
    int b;
    b = 1000;
    while ((cyc - t_e + 1) < target && b > 0) begin
      tick();
      b--;
    end
  endtask

  function automatic int rd_d_at(int i);
    return (i < rd_d.size()) ? rd_d[i] : -1;
  endfunction

  function automatic int rd_a_at(int i);
    return (i < rd_a.size()) ? rd_a[i] : -1;
  endfunction

  initial begin
    int exp_rd[3];
    int bad;
    for (int i = 0; i < 32; i++) mem[i] = 2'b00;
    repeat (3) tick();
    check("reset outputs",
          32'({mem_rd, addr, led_yellow, led_blue, led_green, led_red, busy, done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: {2,0,3}, fast
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    exp_rd = '{1, 9, 17};
    do_start(3, 1'b1);
    wait_done(100, "t1");
    check("t1 read count", rd_d.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1 read %0d cycle", i), rd_d_at(i), exp_rd[i]);
      check($sformatf("t1 read %0d addr", i), rd_a_at(i), i);
    end
    check("t1 first led cycle", led_d, 3);
    check("t1 first led blue", 32'(led_v), 32'h4);
    check("t1 done cycle", done_d, 25);
    check("t1 done count", done_cnt, 1);

    // T2: same sequence, slow
    do_start(3, 1'b0);
    wait_done(200, "t2");
    check("t2 read 1 cycle", rd_d_at(1), 13);
    check("t2 done cycle", done_d, 37);

    // T3: length 0
    do_start(0, 1'b1);
    wait_done(10, "t3");
    check("t3 done cycle", done_d, 1);
    check("t3 no reads", rd_d.size(), 0);
    check("t3 no leds", led_d, -1);
    check("t3 done count", done_cnt, 1);

    // T4: abort in second SHOW cycle of item index 1
    do_start(3, 1'b1);
    wait_d(12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4 busy after abort", 32'(busy), 32'd0);
    check("t4 leds after abort", 32'({led_yellow, led_blue, led_green, led_red}), 32'd0);
    repeat (40) tick();
    check("t4 no done", done_cnt, 0);
    check("t4 reads before abort", rd_d.size(), 2);
    do_start(3, 1'b1);
    wait_done(100, "t4 replay");
    check("t4 replay first addr", rd_a_at(0), 0);
    check("t4 replay done cycle", done_d, 25);

    // T5: start during GAP is ignored
    do_start(3, 1'b1);
    wait_d(7);
    length = 6'd1;
    speed  = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, "t5");
    check("t5 done cycle", done_d, 25);
    check("t5 read count", rd_d.size(), 3);

    // T6: length 40 clamps to 32 items
    for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
    do_start(40, 1'b1);
    wait_done(400, "t6");
    check("t6 read count", rd_d.size(), 32);
    check("t6 last addr", rd_a_at(31), 31);
    bad = 0;
    for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] != i) bad++;
    check("t6 addr sequence", bad, 0);
    check("t6 done cycle", done_d, 257);

    // T7: async reset during item index 4
    do_start(32, 1'b1);
    wait_d(36);
    rst_n = 1'b0;
    #1;
    check("t7 async reset outputs",
          32'({mem_rd, addr, led_yellow, led_blue, led_green, led_red, busy, done}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t7 idle after reset", 32'(busy), 32'd0);
    check("t7 no done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
